// File: rtl/mux8_arb_pkg.sv
// Shared types and sizing helpers for the round-robin mux8 arbiter.
package mux8_arb_pkg;

    localparam int N  = 8;
    localparam int SW = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Width of a counter that must reach max_hold-1; never narrower than one bit.
    function automatic int cnt_width(input int max_hold);
        if (max_hold <= 2) begin
            return 1;
        end
        return $clog2(max_hold);
    endfunction

    function automatic logic [N-1:0] onehot(input logic [SW-1:0] idx);
        logic [N-1:0] one;
        one = {{(N-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/mux8.sv
// Existing 8:1 single-bit datapath mux.
module mux8 (
    input  logic [7:0] a,
    input  logic [2:0] s,
    output logic       y
);

    always_comb begin
        y = a[s];
    end

endmodule

// File: rtl/mux8_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from last+1, wrapping.
module rr_pick
    import mux8_arb_pkg::*;
(
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] last,
    output logic          found,
    output logic [SW-1:0] idx
);

    logic [SW-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        // Offset N wraps back onto last itself, so the previous owner is checked last.
        for (int k = 1; k <= N; k++) begin
            cand = last + SW'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter owning the select of one mux8 channel shared by 8 requesters.
//   state | meaning
//   IDLE  | no grant active, gnt=0, valid=0, s holds its last value
//   GRANT | source s owns the mux, gnt one-hot, valid=1, cnt counts held cycles
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  a,
    input  logic          done,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] s,
    output logic          y,
    output logic          valid
);

    localparam int            CW       = cnt_width(MAX_HOLD);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

    state_e        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [SW-1:0] s_q, s_d;
    logic [SW-1:0] last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [SW-1:0] pick_last;
    logic          pick_found;
    logic [SW-1:0] pick_idx;
    logic          release_c;
    logic          y_raw;

    // On release the new last is the outgoing s, so the picker looks past s directly.
    always_comb begin
        pick_last = (state_q == GRANT) ? s_q : last_q;
    end

    rr_pick u_pick (
        .req   (req),
        .last  (pick_last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    mux8 u_mux (
        .a (a),
        .s (s_q),
        .y (y_raw)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        s_d       = s_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        release_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    s_d     = pick_idx;
                    gnt_d   = onehot(pick_idx);
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                release_c = !req[s_q] || done || (cnt_q == CNT_LAST);
                if (!release_c) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    last_d = s_q;
                    cnt_d  = '0;
                    if (pick_found) begin
                        s_d   = pick_idx;
                        gnt_d = onehot(pick_idx);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            s_q     <= '0;
            last_q  <= SW'(N - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        gnt   = gnt_q;
        s     = s_q;
        valid = (state_q == GRANT);
        y     = valid & y_raw;
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Randomized and directed checks of mux8_rr_arbiter (MAX_HOLD=4 and 2) against a behavioural model.
module tb_mux8_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] a;
    logic       done;

    logic [7:0] gnt4, gnt2;
    logic [2:0] s4, s2;
    logic       y4, y2, valid4, valid2;

    int n_vec = 0;
    int n_err = 0;

    int m_busy [2];
    int m_s    [2];
    int m_cnt  [2];
    int m_last [2];
    int hold   [2] = '{4, 2};

    always #5 clk = ~clk;

    mux8_rr_arbiter #(.MAX_HOLD(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req), .a(a), .done(done),
        .gnt(gnt4), .s(s4), .y(y4), .valid(valid4)
    );

    mux8_rr_arbiter #(.MAX_HOLD(2)) u_dut2 (
        .clk(clk), .rst(rst), .req(req), .a(a), .done(done),
        .gnt(gnt2), .s(s2), .y(y2), .valid(valid2)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_winner(input logic [7:0] r, input int last);
        for (int off = 1; off <= 8; off++) begin
            if (r[(last + off) % 8]) return (last + off) % 8;
        end
        return -1;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_busy[k] = 0; m_s[k] = 0; m_cnt[k] = 0; m_last[k] = 7;
            end else if (m_busy[k] == 0) begin
                if (req != 8'h00) begin
                    m_busy[k] = 1;
                    m_s[k]    = rr_winner(req, m_last[k]);
                    m_cnt[k]  = 0;
                end
            end else if (req[m_s[k]] && !done && m_cnt[k] != hold[k] - 1) begin
                m_cnt[k]++;
            end else begin
                m_last[k] = m_s[k];
                m_cnt[k]  = 0;
                if (req != 8'h00) m_s[k] = rr_winner(req, m_last[k]);
                else              m_busy[k] = 0;
            end
        end
    endtask

    function automatic logic [7:0] exp_gnt(input int k);
        return (m_busy[k] != 0) ? 8'(1 << m_s[k]) : 8'h00;
    endfunction

    function automatic logic exp_y(input int k);
        return (m_busy[k] != 0) ? a[m_s[k]] : 1'b0;
    endfunction

    task automatic compare_all();
        check("gnt4",   gnt4,         exp_gnt(0));
        check("s4",     {5'b0, s4},   8'(m_s[0]));
        check("valid4", {7'b0, valid4}, 8'(m_busy[0]));
        check("y4",     {7'b0, y4},   {7'b0, exp_y(0)});
        check("gnt2",   gnt2,         exp_gnt(1));
        check("s2",     {5'b0, s2},   8'(m_s[1]));
        check("valid2", {7'b0, valid2}, 8'(m_busy[1]));
        check("y2",     {7'b0, y2},   {7'b0, exp_y(1)});
    endtask

    task automatic step(input logic [7:0] r, input logic [7:0] av, input logic d, input logic rs);
        req = r; a = av; done = d; rst = rs;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    logic [2:0] exp_s1 [9] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0};
    logic [7:0] r_rand;

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_s[k] = 0; m_cnt[k] = 0; m_last[k] = 7;
        end
        req = 8'h00; a = 8'h00; done = 1'b0; rst = 1'b1;

        step(8'h00, 8'h00, 1'b0, 1'b1);
        step(8'h00, 8'h00, 1'b0, 1'b1);
        check("rst_gnt", gnt4, 8'h00);
        check("rst_s", {5'b0, s4}, 8'h00);
        check("rst_valid", {7'b0, valid4}, 8'h00);

        // Two requesters, MAX_HOLD=4: four cycles each, then back to 0.
        for (int i = 0; i < 9; i++) begin
            step(8'b0000_0101, 8'h00, 1'b0, 1'b0);
            check("rot_s", {5'b0, s4}, {5'b0, exp_s1[i]});
        end

        // Grant to source 3, drop its request after two cycles.
        step(8'h00, 8'h00, 1'b0, 1'b0);
        step(8'b0000_1000, 8'b0000_1000, 1'b0, 1'b0);
        check("drop_y0", {7'b0, y4}, 8'h01);
        step(8'b0000_1000, 8'b0000_1000, 1'b0, 1'b0);
        check("drop_y1", {7'b0, y4}, 8'h01);
        step(8'h00, 8'b0000_1000, 1'b0, 1'b0);
        check("drop_valid", {7'b0, valid4}, 8'h00);
        check("drop_gnt", gnt4, 8'h00);
        check("drop_y", {7'b0, y4}, 8'h00);

        // Wrap-around: 0 first, done moves to 7, next done wraps to 0.
        step(8'h00, 8'h00, 1'b0, 1'b1);
        step(8'b1000_0001, 8'h00, 1'b0, 1'b0);
        check("wrap_first", {5'b0, s4}, 8'd0);
        step(8'b1000_0001, 8'h00, 1'b1, 1'b0);
        check("wrap_to7", {5'b0, s4}, 8'd7);
        step(8'b1000_0001, 8'h00, 1'b1, 1'b0);
        check("wrap_to0", {5'b0, s4}, 8'd0);

        // Single requester on the MAX_HOLD=2 instance never loses its grant.
        step(8'h00, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(8'b0001_0000, 8'h00, 1'b0, 1'b0);
            check("single_gnt", gnt2, 8'b0001_0000);
            check("single_valid", {7'b0, valid2}, 8'h01);
        end

        // Reset in the middle of a grant on source 6.
        step(8'h00, 8'h00, 1'b0, 1'b1);
        step(8'b0100_0000, 8'h40, 1'b0, 1'b0);
        check("mid_s6", {5'b0, s4}, 8'd6);
        step(8'b0100_0000, 8'h40, 1'b0, 1'b1);
        check("mid_rst_gnt", gnt4, 8'h00);
        check("mid_rst_valid", {7'b0, valid4}, 8'h00);
        check("mid_rst_s", {5'b0, s4}, 8'h00);
        step(8'b0100_0000, 8'h40, 1'b0, 1'b0);
        check("mid_regrant", gnt4, 8'b0100_0000);
        check("mid_regrant_s", {5'b0, s4}, 8'd6);

        // done in IDLE with no requests changes nothing.
        step(8'h00, 8'hff, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(8'h00, 8'hff, 1'b1, 1'b0);
            check("idle_done_gnt", gnt4, 8'h00);
            check("idle_done_valid", {7'b0, valid4}, 8'h00);
            check("idle_done_y", {7'b0, y4}, 8'h00);
        end

        // Random traffic, with a combinational y check after a mid-cycle change of a.
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 3))
                0:       r_rand = 8'h00;
                1:       r_rand = 8'(1 << $urandom_range(0, 7));
                default: r_rand = 8'($urandom);
            endcase
            step(r_rand, 8'($urandom), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 63) == 0));
            a = 8'($urandom);
            #1;
            check("y4_comb", {7'b0, y4}, {7'b0, exp_y(0)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
